muldiv_ctrl: RTL
================

Name: muldiv_ctrl

Overview:
Sequencer that sits beside EX and owns the shared multiplier (fixed latency) and the iterative divider (ready handshake) on behalf of mult/multu/div/divu/mthi/mtlo.
It launches the unit, raises the EX stall request for the whole operation, and emits one HI/LO write set when the operation completes.
A flush annuls an in-flight operation without any HI/LO write.
Replaces the ad-hoc combinational div/mul control in EX with an explicit FSM.

Parameters:
MUL_LAT, 2, cycles from operands presented on mul_ina/mul_inb to a valid mul_result (range 1..15)
DIV_ZERO_LO, 32'hFFFF_FFFF, LO value written for a divide by zero (HI gets the dividend)

Ports:
clk  in  1  clock, all state on posedge
rst  in  1  synchronous active-high reset
op_valid  in  1  EX holds a HI/LO-class instruction this cycle
op_kind  in  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6-7 ignored (treated as no op)
src_a  in  32  rs value (dividend / multiplicand / mthi-mtlo data)
src_b  in  32  rt value (divisor / multiplier)
ex_hold  in  1  EX is frozen by a later stage; a completed result must be held
flush  in  1  annul the current operation
mul_signed  out  1  multiplier signed select
mul_ina  out  32  multiplier operand a
mul_inb  out  32  multiplier operand b
mul_result  in  64  multiplier product
div_start  out  1  divider start (level, held until div_ready)
div_signed  out  1  divider signed select
div_opdata1  out  32  dividend
div_opdata2  out  32  divisor
div_annul  out  1  divider abort, one-cycle pulse
div_ready  in  1  divider result valid
div_result  in  64  {remainder, quotient}
stallreq  out  1  stall request to the stall controller
hi_we  out  1  HI write enable
hi_wdata  out  32  HI write data
lo_we  out  1  LO write enable
lo_wdata  out  32  LO write data
busy  out  1  FSM not in IDLE

Behaviour:
- Reset: state IDLE, counter 0, result registers 0. Every output is 0 during and after reset until a new op_valid arrives.
- States: IDLE, MUL, DIV, DONE. Operands and kind are latched at launch. mul_*/div_op* are driven from the latched copies, so EX may change its operands freely.
- IDLE, op_valid with kind mthi/mtlo:
  - Combinational single-cycle write, no stall, stay in IDLE.
  - mthi: hi_we=1, hi_wdata=src_a. mtlo: lo_we=1, lo_wdata=src_a.
- IDLE, op_valid with kind mult/multu:
  - Latch operands and set mul_signed (1 only for mult).
  - Load counter=MUL_LAT, go to MUL. stallreq=1 combinationally in the launch cycle.
- IDLE, op_valid with kind div/divu:
  - If src_b==0: latch {HI=src_a, LO=DIV_ZERO_LO} and go to DONE. stallreq=1 for the launch cycle.
  - Otherwise latch operands and set div_signed (1 only for div), go to DIV. stallreq=1.
- MUL: counter decrements each cycle. When it reaches 1, capture mul_result into the result registers and go to DONE. Total stall = MUL_LAT+1 cycles (launch + MUL cycles), then DONE.
- DIV: div_start=1 while div_ready==0. On div_ready=1, capture div_result ({HI, LO} = {remainder, quotient}), drop div_start in that same cycle, go to DONE.
- DONE:
  - stallreq=0; hi_we=lo_we=1 with the captured data.
  - If ex_hold=1, stay in DONE with identical outputs (rewrites are idempotent). Otherwise return to IDLE next cycle.
  - op_valid seen in DONE is the same instruction and is ignored. A new launch is only accepted in IDLE.
- stallreq=1 in MUL and DIV and in any launch cycle; 0 in IDLE otherwise and in DONE.
- flush (highest priority after rst), in any state:
  - Next state IDLE; no hi_we/lo_we in the flush cycle.
  - div_annul=1 for one cycle if the state was DIV.
  - A flush in the same cycle as a launch suppresses the launch, including mthi/mtlo writes.
- busy = (state != IDLE).

Optional Feature:
MULDIV_PERF_CNT_EN: adds port stall_cycles out 32, a counter of cycles with stallreq=1.
- Reset to 0; wraps at 2^32.
- Not cleared by flush.
- Without the macro the port and the counter are absent.

Test Plan:
- mult src_a=32'hFFFF_FFFE, src_b=3, MUL_LAT=2 -> stallreq high 3 cycles, then DONE with hi_wdata=32'hFFFF_FFFF, lo_wdata=32'hFFFF_FFFA; hi_we=lo_we=1 for exactly 1 cycle.
- divu 100/7, divider model ready after 33 cycles -> div_start held until ready, stallreq high every cycle until DONE, HI=2, LO=14.
- div src_a=-7, src_b=0 -> no div_start ever; next cycle DONE with HI=32'hFFFF_FFF9, LO=DIV_ZERO_LO.
- mthi src_a=32'h1234_5678 -> same cycle hi_we=1, hi_wdata=32'h1234_5678, stallreq=0, lo_we=0.
- div 20/3 with flush at cycle 5 of DIV -> div_annul pulse, IDLE next cycle, no hi_we/lo_we; then mult 4*5 -> LO=20, HI=0.
- mult finishes while ex_hold=1 for 4 cycles -> DONE held 4 cycles with constant data, IDLE one cycle after ex_hold drops; rst mid-DIV -> all outputs 0 next cycle.

Source files
------------

// File: rtl/muldiv_ctrl.sv
// HI/LO sequencer for mult/multu/div/divu/mthi/mtlo: owns the shared multiplier and divider.
// Optional `MULDIV_PERF_CNT_EN adds a stall_cycles counter port.
module muldiv_ctrl #(
    parameter int unsigned MUL_LAT     = 2,
    parameter logic [31:0] DIV_ZERO_LO = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [2:0]  op_kind,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        ex_hold,
    input  logic        flush,
    output logic        mul_signed,
    output logic [31:0] mul_ina,
    output logic [31:0] mul_inb,
    input  logic [63:0] mul_result,
    output logic        div_start,
    output logic        div_signed,
    output logic [31:0] div_opdata1,
    output logic [31:0] div_opdata2,
    output logic        div_annul,
    input  logic        div_ready,
    input  logic [63:0] div_result,
    output logic        stallreq,
    output logic        hi_we,
    output logic [31:0] hi_wdata,
    output logic        lo_we,
    output logic [31:0] lo_wdata,
`ifdef MULDIV_PERF_CNT_EN
    output logic [31:0] stall_cycles,
`endif
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t      state, state_nx;
    logic [3:0]  cnt, cnt_nx;
    logic [31:0] a_q, a_nx, b_q, b_nx;
    logic [31:0] hi_q, hi_nx, lo_q, lo_nx;
    logic        msgn_q, msgn_nx, dsgn_q, dsgn_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            msgn_q <= 1'b0;
            dsgn_q <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            a_q    <= a_nx;
            b_q    <= b_nx;
            hi_q   <= hi_nx;
            lo_q   <= lo_nx;
            msgn_q <= msgn_nx;
            dsgn_q <= dsgn_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        a_nx      = a_q;
        b_nx      = b_q;
        hi_nx     = hi_q;
        lo_nx     = lo_q;
        msgn_nx   = msgn_q;
        dsgn_nx   = dsgn_q;
        stallreq  = 1'b0;
        div_start = 1'b0;
        div_annul = 1'b0;
        hi_we     = 1'b0;
        hi_wdata  = '0;
        lo_we     = 1'b0;
        lo_wdata  = '0;

        case (state)
            IDLE: begin
                if (op_valid && !flush) begin
                    case (op_kind)
                        3'd0, 3'd1: begin
                            a_nx     = src_a;
                            b_nx     = src_b;
                            msgn_nx  = (op_kind == 3'd0);
                            cnt_nx   = 4'(MUL_LAT);
                            state_nx = MUL;
                            stallreq = 1'b1;
                        end
                        3'd2, 3'd3: begin
                            stallreq = 1'b1;
                            if (src_b == '0) begin
                                hi_nx    = src_a;
                                lo_nx    = DIV_ZERO_LO;
                                state_nx = DONE;
                            end else begin
                                a_nx     = src_a;
                                b_nx     = src_b;
                                dsgn_nx  = (op_kind == 3'd2);
                                state_nx = DIV;
                            end
                        end
                        3'd4: begin
                            hi_we    = 1'b1;
                            hi_wdata = src_a;
                        end
                        3'd5: begin
                            lo_we    = 1'b1;
                            lo_wdata = src_a;
                        end
                        default: ;
                    endcase
                end
            end
            MUL: begin
                stallreq = 1'b1;
                cnt_nx   = cnt - 4'd1;
                if (cnt <= 4'd1) begin
                    hi_nx    = mul_result[63:32];
                    lo_nx    = mul_result[31:0];
                    state_nx = DONE;
                end
            end
            DIV: begin
                stallreq = 1'b1;
                if (div_ready) begin
                    hi_nx    = div_result[63:32];
                    lo_nx    = div_result[31:0];
                    state_nx = DONE;
                end else begin
                    div_start = 1'b1;
                end
            end
            DONE: begin
                hi_we    = 1'b1;
                hi_wdata = hi_q;
                lo_we    = 1'b1;
                lo_wdata = lo_q;
                if (!ex_hold) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase

        // flush overrides the case above: launches and writes are dropped, a running divide is aborted
        if (flush) begin
            state_nx  = IDLE;
            hi_we     = 1'b0;
            hi_wdata  = '0;
            lo_we     = 1'b0;
            lo_wdata  = '0;
            div_annul = (state == DIV);
        end

        if (rst) begin
            stallreq  = 1'b0;
            div_start = 1'b0;
            div_annul = 1'b0;
            hi_we     = 1'b0;
            hi_wdata  = '0;
            lo_we     = 1'b0;
            lo_wdata  = '0;
        end
    end

    assign mul_signed  = rst ? 1'b0 : msgn_q;
    assign mul_ina     = rst ? '0 : a_q;
    assign mul_inb     = rst ? '0 : b_q;
    assign div_signed  = rst ? 1'b0 : dsgn_q;
    assign div_opdata1 = rst ? '0 : a_q;
    assign div_opdata2 = rst ? '0 : b_q;
    assign busy        = !rst && (state != IDLE);

`ifdef MULDIV_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)           stall_cycles <= '0;
        else if (stallreq) stall_cycles <= stall_cycles + 32'd1;
    end
`endif

endmodule
